// File: rtl/rsr_shift_sequencer.sv
// Decode-stage micro-sequencer for register-shifted-register ops: borrows read port 2
// for one cycle to fetch Rs, then releases the op into execute with pre-decoded shift flags.
module rsr_shift_sequencer #(
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [31:0]     InstrD,
    input  logic            validD,
    input  logic            isRSRtypeD,
    input  logic            StallD,
    input  logic            FlushD,
    input  logic            StallE,
    input  logic            FlushE,
    input  logic [31:0]     RD2D,
    output logic            seqUseRsD,
    output logic [3:0]      seqRA2D,
    output logic            seqStallF,
    output logic            seqStallD,
    output logic            seqBubbleE,
    output logic            rsrValidE,
    output logic [31:0]     RsValE,
    output logic [1:0]      shiftOpE,
    output logic            amtZeroE,
    output logic            amtLt32E,
    output logic            amtEq32E,
    output logic            rorZeroE,
    output logic [CNTW-1:0] stallCount
);

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    state_t          state_reg, state_next;
    logic [31:0]     rs_hold_reg, rs_hold_next;
    logic [1:0]      shift_op_hold_reg, shift_op_hold_next;
    logic [CNTW-1:0] stall_count_reg;

    logic trig;
    logic seq_active;
    logic release_e;
    logic amt_zero, amt_lt32, amt_eq32, ror_zero;

    // Only the Rs field and shift type are consumed; RD2D is captured whole.
    logic unused_instr_bits;
    assign unused_instr_bits = ^{InstrD[31:12], InstrD[7], InstrD[4:0]};

    assign trig = validD & isRSRtypeD & ~FlushD;

    always_comb begin
        state_next         = state_reg;
        rs_hold_next       = rs_hold_reg;
        shift_op_hold_next = shift_op_hold_reg;
        seq_active         = 1'b0;
        case (state_reg)
            IDLE: begin
                seq_active = trig;
                // A stalled capture is retried so forwarded data can still change Rs.
                if (trig && !StallD) begin
                    rs_hold_next       = RD2D;
                    shift_op_hold_next = InstrD[6:5];
                    state_next         = ISSUE;
                end
            end
            ISSUE: begin
                if (FlushD) begin
                    state_next         = IDLE;
                    rs_hold_next       = '0;
                    shift_op_hold_next = '0;
                end else if (!StallD) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign seqUseRsD  = seq_active;
    assign seqRA2D    = seq_active ? InstrD[11:8] : 4'd0;
    assign seqStallF  = seq_active;
    assign seqStallD  = seq_active;
    assign seqBubbleE = seq_active;

    assign release_e = (state_reg == ISSUE) & ~StallD & ~FlushD;

    // Shift-amount classification on the low byte only, as the shifter uses it.
    assign amt_zero = (rs_hold_reg[7:0] == 8'd0);
    assign amt_lt32 = (rs_hold_reg[7:0] <  8'd32);
    assign amt_eq32 = (rs_hold_reg[7:0] == 8'd32);
    assign ror_zero = (rs_hold_reg[4:0] == 5'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg         <= IDLE;
            rs_hold_reg       <= '0;
            shift_op_hold_reg <= '0;
        end else begin
            state_reg         <= state_next;
            rs_hold_reg       <= rs_hold_next;
            shift_op_hold_reg <= shift_op_hold_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count_reg <= '0;
        end else if (seq_active && (stall_count_reg != {CNTW{1'b1}})) begin
            stall_count_reg <= stall_count_reg + 1'b1;
        end
    end

    assign stallCount = stall_count_reg;

    always_ff @(posedge clk) begin
        if (reset || FlushE) begin
            rsrValidE <= 1'b0;
            RsValE    <= '0;
            shiftOpE  <= '0;
            amtZeroE  <= 1'b0;
            amtLt32E  <= 1'b0;
            amtEq32E  <= 1'b0;
            rorZeroE  <= 1'b0;
        end else if (!StallE) begin
            if (release_e) begin
                rsrValidE <= 1'b1;
                RsValE    <= rs_hold_reg;
                shiftOpE  <= shift_op_hold_reg;
                amtZeroE  <= amt_zero;
                amtLt32E  <= amt_lt32;
                amtEq32E  <= amt_eq32;
                rorZeroE  <= ror_zero;
            end else begin
                rsrValidE <= 1'b0;
                RsValE    <= '0;
                shiftOpE  <= '0;
                amtZeroE  <= 1'b0;
                amtLt32E  <= 1'b0;
                amtEq32E  <= 1'b0;
                rorZeroE  <= 1'b0;
            end
        end
    end

endmodule

// File: doc/rsr_shift_sequencer.md
# rsr_shift_sequencer

Decode-stage micro-sequencer for register-shifted-register (RSR) data-processing instructions in the pipelined core. The register file has two read ports, but an RSR instruction needs three operands: Rn, Rm and Rs. This block steals read port 2 for one cycle to fetch Rs, stalls fetch and decode, and injects a bubble into execute. It then releases the instruction with Rs and pre-decoded shift-amount flags registered alongside it, so the execute-stage shifter only selects and does not compare.

## Interface
Parameters:
- CNTW, 16, width of saturating stall-cycle counter

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high
- InstrD  in  32  instruction in decode
- validD  in  1  InstrD holds a real instruction
- isRSRtypeD  in  1  decode flags InstrD as RSR: [27:25]=000, [7]=0, [4]=1
- StallD  in  1  hazard-unit decode stall
- FlushD  in  1  hazard-unit decode flush
- StallE  in  1  hold execute pipeline registers
- FlushE  in  1  clear execute pipeline registers
- RD2D  in  32  register-file read port 2 data
- seqUseRsD  out  1  port 2 address mux selects InstrD[11:8]
- seqRA2D  out  4  port 2 address while seqUseRsD=1 (InstrD[11:8]), else 0
- seqStallF  out  1  extra fetch stall
- seqStallD  out  1  extra decode stall
- seqBubbleE  out  1  force bubble into execute
- rsrValidE  out  1  execute instruction is an RSR op with valid Rs fields
- RsValE  out  32  latched Rs value, to shifter a input
- shiftOpE  out  2  InstrD[6:5] of the RSR op
- amtZeroE  out  1  RsValE[7:0]==0
- amtLt32E  out  1  RsValE[7:0]<32, including 0
- amtEq32E  out  1  RsValE[7:0]==32
- rorZeroE  out  1  RsValE[4:0]==0
- stallCount  out  CNTW  saturating count of sequencer-inserted stall cycles

## Operation
- States: IDLE, ISSUE. Reset forces IDLE.
- trig = validD & isRSRtypeD & ~FlushD.
- IDLE:
  - seqUseRsD = seqStallF = seqStallD = seqBubbleE = trig.
  - If trig & ~StallD: RsHold <= RD2D, shiftOpHold <= InstrD[6:5], next state ISSUE.
  - If trig & StallD: remain IDLE and re-read Rs next cycle, because a forwarding or load hazard can change RD2D.
- ISSUE:
  - All seq* outputs are 0, so port 2 reads Rm normally and the instruction is allowed to advance.
  - FlushD: go to IDLE and discard RsHold.
  - StallD (without FlushD): hold state and RsHold.
  - Otherwise: the instruction advances to execute this cycle, and the state returns to IDLE.
- Execute registers (rsrValidE, RsValE, shiftOpE and the four flags) follow this priority: reset > FlushE > StallE > load.
  - Reset or FlushE: all cleared to 0.
  - StallE: hold.
  - Load when state=ISSUE & ~StallD & ~FlushD:
    - rsrValidE <= 1, RsValE <= RsHold, shiftOpE <= shiftOpHold.
    - Flags are computed from RsHold.
  - Any other load: rsrValidE <= 0 and the data fields <= 0.
- Flag arithmetic uses unsigned compares on RsHold[7:0]. The upper 24 bits are ignored.
  - Amounts 33..255: amtLt32E=0, amtEq32E=0.
- stallCount: increments on each cycle with seqStallD=1 and saturates at 2^CNTW-1. It resets to 0 and is never wrapped.
- Back-to-back RSR ops: ISSUE→IDLE, then the new op triggers. This costs one stall cycle per RSR op.
- Rs = r15: RD2D is used as supplied by the register file (PC+8). No special handling.

## Timing
- Reset values: state=IDLE, RsHold=0, all E outputs 0, stallCount=0. Comb outputs are 0 while validD=0.
- seq* outputs are combinational from InstrD, validD, FlushD and state. There is no dependence on RD2D.
- Latency: an RSR op spends 2 cycles in decode when unstalled (IDLE then ISSUE). It reaches execute 1 cycle later than a non-RSR op.
- Execute-stage outputs are valid the cycle after the load condition and are stable while StallE=1.
- FlushD and StallD in the same cycle: FlushD wins.
- FlushE and a load in the same cycle: FlushE wins, so the E outputs become 0. The state still returns to IDLE.
- Reset asserted in ISSUE: next cycle is IDLE with all outputs 0, and RsHold is lost.

## Test plan
- RSR op with Rs=0x00000005, no stalls: cycle 0 seqUseRsD=seqStallD=seqBubbleE=1 and seqRA2D=InstrD[11:8]. Cycle 1 all seq*=0. Cycle 2 rsrValidE=1, RsValE=5, amtLt32E=1, amtZeroE=0. stallCount=1.
- Rs=0x120 (low byte 0x20): amtEq32E=1, amtLt32E=0, rorZeroE=1. Rs=0x21: all of amtEq32E, amtLt32E and amtZeroE are 0. Rs=0xFFFFFF00: amtZeroE=1, amtLt32E=1.
- StallD held 3 cycles in IDLE with an RSR op while RD2D changes 1→2→3, then released: RsValE=3, and stallCount=4.
- FlushD in ISSUE: the next cycle is IDLE and the next execute load gives rsrValidE=0. FlushE on the load cycle gives all E outputs 0.
- Two consecutive RSR ops with Rs=7 then Rs=40: each spends 2 decode cycles. Execute sees RsValE=7 then 40 with one bubble between them, and stallCount=2.
- Reset asserted mid-ISSUE: the next cycle has state IDLE and all outputs 0. A non-RSR op afterwards passes with seq*=0 and rsrValidE=0.
